// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: stalls ID for load-use and in-flight mul/div dependencies,
// sequences the multi-cycle mul/div unit and arbitrates its late register-file write-back.
module hazard_scoreboard #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_valid,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_uses_RS1,
    input  logic       ID_uses_RS2,
    input  logic [4:0] ID_RD,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_MulDiv,
    input  logic       flush,
    input  logic       MEM_WB_RegWrite,
    output logic       stall,
    output logic       ID_EX_bubble,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_wb_valid,
    output logic [4:0] md_wb_rd
);

    typedef enum logic [1:0] {StIdle, StBusy, StWbWait} md_state_e;

    md_state_e        state_q, state_d;
    logic             ld_valid_q, ld_valid_d;
    logic [4:0]       ld_rd_q;
    logic [4:0]       md_rd_q, md_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start_q, md_start_d;

    logic issue;
    logic match_ld, match_md;
    logic load_use, md_raw, md_struct, md_waw;

    assign match_ld = (ID_uses_RS1 & (ID_RS1 == ld_rd_q)) | (ID_uses_RS2 & (ID_RS2 == ld_rd_q));
    assign match_md = (ID_uses_RS1 & (ID_RS1 == md_rd_q)) | (ID_uses_RS2 & (ID_RS2 == md_rd_q));

    assign md_busy   = (state_q != StIdle);
    // ld_rd_q is never x0 while ld_valid_q is set, so x0 sources cannot match it
    assign load_use  = ld_valid_q & match_ld;
    assign md_raw    = md_busy & (md_rd_q != 5'd0) & match_md;
    assign md_struct = ID_MulDiv & md_busy;
    assign md_waw    = md_busy & ID_RegWrite & (ID_RD != 5'd0) & (ID_RD == md_rd_q);

    assign stall        = ID_valid & ~flush & (load_use | md_raw | md_struct | md_waw);
    assign ID_EX_bubble = stall | flush;
    assign issue        = ID_valid & ~stall & ~flush;
    assign md_start     = md_start_q;

    assign ld_valid_d = issue & ID_MemRead & ID_RegWrite & (ID_RD != 5'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_rd_d     = md_rd_q;
        md_start_d  = 1'b0;
        md_wb_valid = 1'b0;
        md_wb_rd    = 5'd0;
        case (state_q)
            StIdle: begin
                if (issue & ID_MulDiv) begin
                    md_rd_d    = ID_RegWrite ? ID_RD : 5'd0;
                    cnt_d      = CNT_W'(MD_LATENCY - 1);
                    md_start_d = 1'b1;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = (md_rd_q != 5'd0) ? StWbWait : StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWbWait: begin
                // The main pipeline always owns the write port when it needs it
                if (!MEM_WB_RegWrite) begin
                    md_wb_valid = 1'b1;
                    md_wb_rd    = md_rd_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= 5'd0;
            md_rd_q    <= 5'd0;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ID_RD;
            md_rd_q    <= md_rd_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
        end
    end

endmodule
